// File: rtl/ftdnn_pkg.sv
// Shared types and sizing for the super-block activation feeder.
// Contents:
//   feeder_state_e  - tile sequencing states used by ftdnn_act_feeder
//   ACT_DATA_LEN    - width of one activation word
//   ACT_PAIR_LEN    - width of one packed actbuf word {hi,lo}
//   XLT_DATA_LEN    - width of the super-block parameter word
//   SBLK_ROWS       - number of super-block rows
//   FEEDER_CNT_W    - default width of the tile length counter
`ifndef ACTBUF_DATA_LEN
`define ACTBUF_DATA_LEN 8
`endif
`ifndef HW_XLT_LEN
`define HW_XLT_LEN 8
`endif
`ifndef HW_D3
`define HW_D3 4
`endif

package ftdnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_STREAM = 3'd3,
        S_DONE   = 3'd4
    } feeder_state_e;

    localparam int ACT_DATA_LEN = `ACTBUF_DATA_LEN;
    localparam int ACT_PAIR_LEN = 2 * `ACTBUF_DATA_LEN;
    localparam int XLT_DATA_LEN = `HW_XLT_LEN;
    localparam int SBLK_ROWS    = `HW_D3;
    localparam int FEEDER_CNT_W = 16;

endpackage

// File: rtl/ftdnn_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset (empties the FIFO)
//   push   in   1      write din this cycle (accepted if not full, or full and popping)
//   pop    in   1      consume dout this cycle (ignored when empty)
//   din    in   WIDTH  write data
//   dout   out  WIDTH  head entry, valid whenever empty=0
//   full   out  1      no free entries
//   empty  out  1      no stored entries
module ftdnn_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ftdnn_act_feeder.sv
// Activation feeder for the super-block array actbuf port.
// Loads a tile parameter word into all super-block rows, waits for every row
// to report ready, then packs pairs of activation words into {hi,lo} and
// streams them into the array under its req/vld handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for cfg_start; parameter and length latched on it
// S_LOAD   | sblk_param_en high for this single cycle
// S_WAIT   | waiting for sblk_status all-ones; len==0 skips to S_DONE
// S_STREAM | accepting words, packing pairs, draining FIFO to actbuf
// S_DONE   | cfg_done pulse, cfg_busy still high
//
// Ports:
//   clk_l           in   1          clock, rising edge
//   rst_n           in   1          asynchronous active-low reset
//   cfg_start       in   1          tile start pulse (ignored while busy)
//   cfg_param       in   XLT_LEN    tile parameter word
//   cfg_len         in   CNT_W      number of packed pairs in the tile
//   cfg_busy        out  1          tile in progress
//   cfg_done        out  1          last pair delivered pulse
//   s_data          in   ACT_LEN    activation word
//   s_vld           in   1          s_data valid
//   s_rdy           out  1          feeder can accept s_data
//   sblk_param      out  XLT_LEN    parameter word to all rows
//   sblk_param_en   out  1          load strobe for sblk_param
//   sblk_status     in   D3         per-row ready
//   actbuf_wr_data  out  2*ACT_LEN  packed pair {hi,lo}, zero when empty
//   actbuf_wr_vld   out  1          pair transferred this cycle
//   actbuf_wr_req   in   1          array can take a pair this cycle
module ftdnn_act_feeder
    import ftdnn_pkg::*;
#(
    parameter int ACT_LEN    = ACT_DATA_LEN,
    parameter int XLT_LEN    = XLT_DATA_LEN,
    parameter int D3         = SBLK_ROWS,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = FEEDER_CNT_W
) (
    input  logic                 clk_l,
    input  logic                 rst_n,
    input  logic                 cfg_start,
    input  logic [XLT_LEN-1:0]   cfg_param,
    input  logic [CNT_W-1:0]     cfg_len,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    input  logic [ACT_LEN-1:0]   s_data,
    input  logic                 s_vld,
    output logic                 s_rdy,
    output logic [XLT_LEN-1:0]   sblk_param,
    output logic                 sblk_param_en,
    input  logic [D3-1:0]        sblk_status,
    output logic [2*ACT_LEN-1:0] actbuf_wr_data,
    output logic                 actbuf_wr_vld,
    input  logic                 actbuf_wr_req
);

    feeder_state_e        state;
    logic [CNT_W-1:0]     len_q;
    logic [CNT_W-1:0]     out_cnt;
    logic [CNT_W:0]       in_cnt;
    logic                 half_pending;
    logic [ACT_LEN-1:0]   lo_reg;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2*ACT_LEN-1:0] fifo_dout;
    logic                 in_fire;
    logic                 last_pop;

    // The second word of a pair only goes in if the FIFO has room; a lone
    // lo word can always be parked in lo_reg.
    assign s_rdy = (state == S_STREAM) && (in_cnt < {len_q, 1'b0})
                   && (!fifo_full || !half_pending);
    assign in_fire   = s_vld && s_rdy;
    assign fifo_push = in_fire && half_pending;

    assign fifo_pop       = !fifo_empty && actbuf_wr_req;
    assign actbuf_wr_vld  = fifo_pop;
    assign actbuf_wr_data = fifo_empty ? '0 : fifo_dout;
    assign last_pop       = fifo_pop && (out_cnt == (len_q - CNT_W'(1)));

    assign cfg_busy = (state != S_IDLE);

    ftdnn_sync_fifo #(
        .WIDTH (2*ACT_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clk   (clk_l),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({s_data, lo_reg}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            len_q         <= '0;
            out_cnt       <= '0;
            in_cnt        <= '0;
            half_pending  <= 1'b0;
            lo_reg        <= '0;
            sblk_param    <= '0;
            sblk_param_en <= 1'b0;
            cfg_done      <= 1'b0;
        end else begin
            sblk_param_en <= 1'b0;
            cfg_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cfg_start) begin
                        sblk_param    <= cfg_param;
                        len_q         <= cfg_len;
                        in_cnt        <= '0;
                        out_cnt       <= '0;
                        half_pending  <= 1'b0;
                        sblk_param_en <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (&sblk_status) begin
                        if (len_q == '0) begin
                            cfg_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            state <= S_STREAM;
                        end
                    end
                end
                S_STREAM: begin
                    if (in_fire) begin
                        in_cnt       <= in_cnt + (CNT_W+1)'(1);
                        half_pending <= !half_pending;
                        if (!half_pending) lo_reg <= s_data;
                    end
                    if (fifo_pop) out_cnt <= out_cnt + CNT_W'(1);
                    if (last_pop) begin
                        cfg_done <= 1'b1;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ftdnn_act_feeder.sv
module tb_ftdnn_act_feeder;
    import ftdnn_pkg::*;

    localparam int AL = ACT_DATA_LEN;
    localparam int PL = ACT_PAIR_LEN;
    localparam int XL = XLT_DATA_LEN;
    localparam int RW = SBLK_ROWS;
    localparam int CW = FEEDER_CNT_W;

    logic          clk_l = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_start = 1'b0;
    logic [XL-1:0] cfg_param = '0;
    logic [CW-1:0] cfg_len = '0;
    logic          cfg_busy;
    logic          cfg_done;
    logic [AL-1:0] s_data = '0;
    logic          s_vld = 1'b0;
    logic          s_rdy;
    logic [XL-1:0] sblk_param;
    logic          sblk_param_en;
    logic [RW-1:0] sblk_status = '1;
    logic [PL-1:0] actbuf_wr_data;
    logic          actbuf_wr_vld;
    logic          actbuf_wr_req = 1'b1;

    ftdnn_act_feeder #(.FIFO_DEPTH(4)) dut (
        .clk_l          (clk_l),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_param      (cfg_param),
        .cfg_len        (cfg_len),
        .cfg_busy       (cfg_busy),
        .cfg_done       (cfg_done),
        .s_data         (s_data),
        .s_vld          (s_vld),
        .s_rdy          (s_rdy),
        .sblk_param     (sblk_param),
        .sblk_param_en  (sblk_param_en),
        .sblk_status    (sblk_status),
        .actbuf_wr_data (actbuf_wr_data),
        .actbuf_wr_vld  (actbuf_wr_vld),
        .actbuf_wr_req  (actbuf_wr_req)
    );

    always #5 clk_l = ~clk_l;

    int n_tests = 0;
    int n_fail  = 0;
    logic [PL-1:0] exp_q[$];

    int cyc = 0;
    int pop_cnt, done_cnt, pe_cnt, rdy_cnt, vld_cnt, last_pop_cyc, done_cyc;
    logic [XL-1:0] last_param;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_mon();
        pop_cnt = 0; done_cnt = 0; pe_cnt = 0; rdy_cnt = 0; vld_cnt = 0;
        last_pop_cyc = -1; done_cyc = -1; last_param = '0;
    endtask

    // Monitor: scoreboard compare on every transferred pair, plus event tallies.
    always @(negedge clk_l) begin
        cyc++;
        if (rst_n) begin
            if (actbuf_wr_vld) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pair_unexpected: got %h expected none", actbuf_wr_data);
                end else begin
                    logic [PL-1:0] e;
                    e = exp_q.pop_front();
                    if (actbuf_wr_data !== e) begin
                        n_fail++;
                        $display("FAIL pair_data: got %h expected %h", actbuf_wr_data, e);
                    end
                end
                pop_cnt++;
                vld_cnt++;
                last_pop_cyc = cyc;
            end
            if (cfg_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sblk_param_en) begin
                pe_cnt++;
                last_param = sblk_param;
            end
            if (s_rdy) rdy_cnt++;
        end
    end

    task automatic start_tile(input logic [XL-1:0] p, input logic [CW-1:0] l);
        cfg_param = p;
        cfg_len   = l;
        cfg_start = 1'b1;
        @(posedge clk_l); #1;
        cfg_start = 1'b0;
    endtask

    // Called just after a rising edge; drives n consecutive words.
    task automatic feed(input int n, input logic [AL-1:0] first);
        int t;
        for (int i = 0; i < n; i++) begin
            s_data = first + AL'(i);
            s_vld  = 1'b1;
            t = 0;
            do begin
                @(negedge clk_l);
                t++;
            end while (!s_rdy && t < 200);
            if (!s_rdy) begin
                check("feed_timeout", 32'(s_rdy), 1);
                break;
            end
            @(posedge clk_l); #1;
        end
        s_vld = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk_l);
            if (cfg_done) begin
                seen = 1'b1;
                check("done_busy", 32'(cfg_busy), 1);
            end
        end
        check("done_seen", 32'(seen), 1);
        @(posedge clk_l); #1;
        check("busy_clear", 32'(cfg_busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int bad;
        logic acc;
        clr_mon();

        // 1: reset state
        repeat (3) @(posedge clk_l);
        #1 rst_n = 1'b1;
        @(negedge clk_l);
        check("rst_busy",  32'(cfg_busy), 0);
        check("rst_done",  32'(cfg_done), 0);
        check("rst_rdy",   32'(s_rdy), 0);
        check("rst_param", 32'(sblk_param), 0);
        check("rst_pen",   32'(sblk_param_en), 0);
        check("rst_vld",   32'(actbuf_wr_vld), 0);
        check("rst_data",  32'(actbuf_wr_data), 0);
        @(posedge clk_l); #1;

        // 2: basic tile, three pairs
        clr_mon();
        sblk_status = '1;
        actbuf_wr_req = 1'b1;
        exp_q.push_back(16'h0201);
        exp_q.push_back(16'h0403);
        exp_q.push_back(16'h0605);
        start_tile(8'h5A, 16'd3);
        feed(6, 8'h01);
        s_vld = 1'b1;
        s_data = 8'h07;
        @(negedge clk_l);
        check("excess_rdy", 32'(s_rdy), 0);
        wait_done(20);
        s_vld = 1'b0;
        check("t2_pen_cnt", 32'(pe_cnt), 1);
        check("t2_param", 32'(last_param), 32'h5A);
        check("t2_pops", 32'(pop_cnt), 3);
        check("t2_done_lat", 32'(done_cyc), 32'(last_pop_cyc + 1));
        check("t2_q_empty", 32'(exp_q.size()), 0);

        // 3: array not ready holds off streaming
        clr_mon();
        sblk_status = '0;
        exp_q.push_back(16'h3231);
        exp_q.push_back(16'h3433);
        start_tile(8'hC3, 16'd2);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_l);
            if (s_rdy) bad++;
        end
        check("t3_rdy_held", 32'(bad), 0);
        sblk_status = '1;
        @(negedge clk_l);
        check("t3_stream_next", 32'(s_rdy), 1);
        @(posedge clk_l); #1;
        feed(4, 8'h31);
        wait_done(20);
        check("t3_q_empty", 32'(exp_q.size()), 0);

        // 4: backpressure fills FIFO, then drains all pairs in order
        clr_mon();
        actbuf_wr_req = 1'b0;
        for (int j = 0; j < 8; j++)
            exp_q.push_back({8'(8'h12 + 2*j), 8'(8'h11 + 2*j)});
        start_tile(8'h11, 16'd8);
        idx = 0;
        s_vld = 1'b1;
        s_data = 8'h11;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_l);
            acc = s_rdy;
            @(posedge clk_l); #1;
            if (acc) begin
                idx++;
                s_data = 8'h11 + AL'(idx);
            end
        end
        check("t4_held_words", 32'(idx), 9);
        @(negedge clk_l);
        check("t4_rdy_full", 32'(s_rdy), 0);
        check("t4_no_vld", 32'(vld_cnt), 0);
        @(posedge clk_l); #1;
        s_vld = 1'b0;
        actbuf_wr_req = 1'b1;
        feed(7, 8'h1A);
        wait_done(60);
        check("t4_pops", 32'(pop_cnt), 8);
        check("t4_q_empty", 32'(exp_q.size()), 0);

        // 5: zero-length tile
        clr_mon();
        s_vld = 1'b1;
        s_data = 8'hEE;
        start_tile(8'h0F, 16'd0);
        wait_done(20);
        s_vld = 1'b0;
        check("t5_pen_cnt", 32'(pe_cnt), 1);
        check("t5_no_rdy", 32'(rdy_cnt), 0);
        check("t5_no_vld", 32'(vld_cnt), 0);
        check("t5_done_cnt", 32'(done_cnt), 1);

        // 6: reset mid-stream discards buffered pairs
        clr_mon();
        actbuf_wr_req = 1'b0;
        start_tile(8'h33, 16'd4);
        feed(4, 8'h41);
        rst_n = 1'b0;
        actbuf_wr_req = 1'b1;
        @(negedge clk_l);
        check("t6_rst_busy", 32'(cfg_busy), 0);
        check("t6_rst_rdy", 32'(s_rdy), 0);
        check("t6_rst_param", 32'(sblk_param), 0);
        check("t6_rst_vld", 32'(actbuf_wr_vld), 0);
        check("t6_rst_data", 32'(actbuf_wr_data), 0);
        @(posedge clk_l); #1;
        @(posedge clk_l); #1;
        rst_n = 1'b1;
        @(posedge clk_l); #1;
        check("t6_no_done", 32'(done_cnt), 0);
        clr_mon();
        exp_q.push_back(16'hB2B1);
        start_tile(8'h77, 16'd1);
        feed(2, 8'hB1);
        wait_done(20);
        check("t6_pops", 32'(pop_cnt), 1);
        check("t6_param", 32'(last_param), 32'h77);
        check("t6_q_empty", 32'(exp_q.size()), 0);

        repeat (3) @(posedge clk_l);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
